// File: rtl/hid_snapshot_accumulator.sv
// Collects HID mouse motion and keyboard state, and freezes a copy for spi_io on each read.
// Mouse deltas accumulate with saturation; the copy is taken once per synchronised hid_read rise.
module hid_snapshot_accumulator #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DELTA_W     = 16,
  parameter int unsigned WHEEL_W     = 8,
  parameter int unsigned ACC_W       = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hid_read,
  input  logic               kbd_connected_in,
  input  logic               mouse_connected_in,
  input  logic               kbd_report_valid,
  input  logic [7:0]         kbd_report_modifiers,
  input  logic [47:0]        kbd_report_keycodes,
  input  logic               mouse_report_valid,
  input  logic [7:0]         mouse_report_buttons,
  input  logic [DELTA_W-1:0] mouse_report_dx,
  input  logic [DELTA_W-1:0] mouse_report_dy,
  input  logic [WHEEL_W-1:0] mouse_report_dwheel,
  output logic               hid_keyboard_connected,
  output logic               hid_mouse_connected,
  output logic [7:0]         hid_keyboard_modifiers,
  output logic [47:0]        hid_keyboard_keycodes,
  output logic [7:0]         hid_mouse_buttons,
  output logic [ACC_W-1:0]   hid_mouse_x,
  output logic [ACC_W-1:0]   hid_mouse_y,
  output logic [ACC_W-1:0]   hid_mouse_wheel,
  output logic               snapshot_strobe
);

  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {StWait, StSnap, StHold} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   read_prev_q;
  logic                   read_sync, read_rise, snap;

  logic [ACC_W-1:0] acc_x_q, acc_y_q, acc_w_q;
  logic [ACC_W-1:0] acc_x_d, acc_y_d, acc_w_d;
  logic [ACC_W-1:0] acc_x_upd, acc_y_upd, acc_w_upd;
  logic [7:0]       buttons_q, buttons_d;
  logic [7:0]       mods_q, mods_d;
  logic [47:0]      keys_q, keys_d;

  logic             kbd_conn_q, mouse_conn_q, strobe_q;
  logic [7:0]       out_mods_q, out_buttons_q;
  logic [47:0]      out_keys_q;
  logic [ACC_W-1:0] out_x_q, out_y_q, out_w_q;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    // Top two bits disagree only on signed overflow; the top bit gives its direction.
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      return sum[ACC_W] ? AccMin : AccMax;
    end
    return sum[ACC_W-1:0];
  endfunction

  assign read_sync = sync_q[SYNC_STAGES-1];
  assign read_rise = read_sync & ~read_prev_q;
  assign snap      = (state_q == StSnap);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait:  if (read_rise) state_d = StSnap;
      StSnap:  state_d = StHold;
      StHold:  if (!read_sync) state_d = StWait;
      default: state_d = StWait;
    endcase
  end

  always_comb begin
    acc_x_upd = acc_x_q;
    acc_y_upd = acc_y_q;
    acc_w_upd = acc_w_q;
    buttons_d = buttons_q;
    if (!mouse_connected_in) begin
      acc_x_upd = '0;
      acc_y_upd = '0;
      acc_w_upd = '0;
      buttons_d = '0;
    end else if (mouse_report_valid) begin
      acc_x_upd = sat_add(acc_x_q,
          {{(ACC_W-DELTA_W){mouse_report_dx[DELTA_W-1]}}, mouse_report_dx});
      acc_y_upd = sat_add(acc_y_q,
          {{(ACC_W-DELTA_W){mouse_report_dy[DELTA_W-1]}}, mouse_report_dy});
      acc_w_upd = sat_add(acc_w_q,
          {{(ACC_W-WHEEL_W){mouse_report_dwheel[WHEEL_W-1]}}, mouse_report_dwheel});
      buttons_d = mouse_report_buttons;
    end
    // A report landing in the snapshot cycle goes into the snapshot, not the next interval.
    acc_x_d = snap ? '0 : acc_x_upd;
    acc_y_d = snap ? '0 : acc_y_upd;
    acc_w_d = snap ? '0 : acc_w_upd;
  end

  always_comb begin
    mods_d = mods_q;
    keys_d = keys_q;
    if (!kbd_connected_in) begin
      mods_d = '0;
      keys_d = '0;
    end else if (kbd_report_valid) begin
      mods_d = kbd_report_modifiers;
      keys_d = kbd_report_keycodes;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      read_prev_q <= 1'b0;
      state_q     <= StWait;
    end else begin
      sync_q[0] <= hid_read;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      read_prev_q <= read_sync;
      state_q     <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_x_q   <= '0;
      acc_y_q   <= '0;
      acc_w_q   <= '0;
      buttons_q <= '0;
      mods_q    <= '0;
      keys_q    <= '0;
    end else begin
      acc_x_q   <= acc_x_d;
      acc_y_q   <= acc_y_d;
      acc_w_q   <= acc_w_d;
      buttons_q <= buttons_d;
      mods_q    <= mods_d;
      keys_q    <= keys_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kbd_conn_q    <= 1'b0;
      mouse_conn_q  <= 1'b0;
      out_mods_q    <= '0;
      out_keys_q    <= '0;
      out_buttons_q <= '0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      out_w_q       <= '0;
      strobe_q      <= 1'b0;
    end else begin
      strobe_q <= snap;
      if (snap) begin
        kbd_conn_q    <= kbd_connected_in;
        mouse_conn_q  <= mouse_connected_in;
        out_mods_q    <= mods_d;
        out_keys_q    <= keys_d;
        out_buttons_q <= buttons_d;
        out_x_q       <= acc_x_upd;
        out_y_q       <= acc_y_upd;
        out_w_q       <= acc_w_upd;
      end
    end
  end

  assign hid_keyboard_connected = kbd_conn_q;
  assign hid_mouse_connected    = mouse_conn_q;
  assign hid_keyboard_modifiers = out_mods_q;
  assign hid_keyboard_keycodes  = out_keys_q;
  assign hid_mouse_buttons      = out_buttons_q;
  assign hid_mouse_x            = out_x_q;
  assign hid_mouse_y            = out_y_q;
  assign hid_mouse_wheel        = out_w_q;
  assign snapshot_strobe        = strobe_q;

endmodule

// File: tb/tb_hid_snapshot_accumulator.sv
// Directed and randomised bench for hid_snapshot_accumulator against an arithmetic model.
// Narrow accumulators keep saturation reachable within a few dozen reports.
module tb_hid_snapshot_accumulator;
  localparam int SS = 2;
  localparam int DW = 16;
  localparam int WW = 8;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          hid_read;
  logic          kbd_connected_in, mouse_connected_in;
  logic          kbd_report_valid;
  logic [7:0]    kbd_report_modifiers;
  logic [47:0]   kbd_report_keycodes;
  logic          mouse_report_valid;
  logic [7:0]    mouse_report_buttons;
  logic [DW-1:0] mouse_report_dx, mouse_report_dy;
  logic [WW-1:0] mouse_report_dwheel;
  logic          hid_keyboard_connected, hid_mouse_connected;
  logic [7:0]    hid_keyboard_modifiers, hid_mouse_buttons;
  logic [47:0]   hid_keyboard_keycodes;
  logic [AW-1:0] hid_mouse_x, hid_mouse_y, hid_mouse_wheel;
  logic          snapshot_strobe;

  hid_snapshot_accumulator #(
    .SYNC_STAGES(SS), .DELTA_W(DW), .WHEEL_W(WW), .ACC_W(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hid_read(hid_read),
    .kbd_connected_in(kbd_connected_in), .mouse_connected_in(mouse_connected_in),
    .kbd_report_valid(kbd_report_valid), .kbd_report_modifiers(kbd_report_modifiers),
    .kbd_report_keycodes(kbd_report_keycodes), .mouse_report_valid(mouse_report_valid),
    .mouse_report_buttons(mouse_report_buttons), .mouse_report_dx(mouse_report_dx),
    .mouse_report_dy(mouse_report_dy), .mouse_report_dwheel(mouse_report_dwheel),
    .hid_keyboard_connected(hid_keyboard_connected), .hid_mouse_connected(hid_mouse_connected),
    .hid_keyboard_modifiers(hid_keyboard_modifiers), .hid_keyboard_keycodes(hid_keyboard_keycodes),
    .hid_mouse_buttons(hid_mouse_buttons), .hid_mouse_x(hid_mouse_x), .hid_mouse_y(hid_mouse_y),
    .hid_mouse_wheel(hid_mouse_wheel), .snapshot_strobe(snapshot_strobe)
  );

  always #5 clk = ~clk;

  // Model: live device state plus the snapshot the outputs should currently show.
  longint      m_x, m_y, m_w, e_x, e_y, e_w;
  logic [7:0]  m_btn, m_mod, e_btn, e_mod;
  logic [47:0] m_keys, e_keys;
  logic        e_kc, e_mc;
  int          checks = 0, failures = 0, strobes = 0;

  function automatic longint sat(input longint v);
    longint mx, mn;
    mx = (longint'(1) <<< (AW - 1)) - 1;
    mn = -(longint'(1) <<< (AW - 1));
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    m_x = 0; m_y = 0; m_w = 0; m_btn = 0; m_mod = 0; m_keys = 0;
    e_x = 0; e_y = 0; e_w = 0; e_btn = 0; e_mod = 0; e_keys = 0; e_kc = 0; e_mc = 0;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".kc"}, 64'(hid_keyboard_connected), 64'(e_kc));
    check({tag, ".mc"}, 64'(hid_mouse_connected), 64'(e_mc));
    check({tag, ".mod"}, 64'(hid_keyboard_modifiers), 64'(e_mod));
    check({tag, ".keys"}, 64'(hid_keyboard_keycodes), 64'(e_keys));
    check({tag, ".btn"}, 64'(hid_mouse_buttons), 64'(e_btn));
    check({tag, ".x"}, 64'(hid_mouse_x), 64'(e_x[AW-1:0]));
    check({tag, ".y"}, 64'(hid_mouse_y), 64'(e_y[AW-1:0]));
    check({tag, ".w"}, 64'(hid_mouse_wheel), 64'(e_w[AW-1:0]));
  endtask

  // Advance one clock; inputs seen at the edge feed the model, and a strobe latches it.
  task automatic step();
    @(posedge clk);
    #1;
    if (!reset_n) begin
      clear_model();
    end else begin
      if (!mouse_connected_in) begin
        m_x = 0; m_y = 0; m_w = 0; m_btn = 0;
      end else if (mouse_report_valid) begin
        m_x = sat(m_x + longint'($signed(mouse_report_dx)));
        m_y = sat(m_y + longint'($signed(mouse_report_dy)));
        m_w = sat(m_w + longint'($signed(mouse_report_dwheel)));
        m_btn = mouse_report_buttons;
      end
      if (!kbd_connected_in) begin
        m_mod = 0; m_keys = 0;
      end else if (kbd_report_valid) begin
        m_mod = kbd_report_modifiers; m_keys = kbd_report_keycodes;
      end
      if (snapshot_strobe) begin
        strobes++;
        e_kc = kbd_connected_in; e_mc = mouse_connected_in;
        e_mod = m_mod; e_keys = m_keys; e_btn = m_btn;
        e_x = m_x; e_y = m_y; e_w = m_w;
        m_x = 0; m_y = 0; m_w = 0;
      end
    end
    check_outs("cyc");
  endtask

  task automatic idle();
    mouse_report_valid = 1'b0;
    kbd_report_valid = 1'b0;
  endtask

  task automatic mouse(input logic [DW-1:0] dx, input logic [DW-1:0] dy,
                       input logic [WW-1:0] dw, input logic [7:0] btn);
    mouse_report_valid = 1'b1;
    mouse_report_dx = dx; mouse_report_dy = dy; mouse_report_dwheel = dw;
    mouse_report_buttons = btn;
  endtask

  task automatic rand_reports(input int pct);
    idle();
    if (int'($urandom_range(99)) < pct) begin
      mouse(DW'($urandom()), DW'($urandom()), WW'($urandom()), 8'($urandom()));
    end
    if (int'($urandom_range(99)) < pct) begin
      kbd_report_valid = 1'b1;
      kbd_report_modifiers = 8'($urandom());
      kbd_report_keycodes = 48'({$urandom(), $urandom()});
    end
  endtask

  // One SPI-style read; force_at >= 0 injects a dx-only report in that cycle of the window.
  task automatic do_read(input int hold, input int pct, input int force_at,
                         input logic [DW-1:0] force_dx);
    int s0, lat;
    s0 = strobes;
    lat = -1;
    hid_read = 1'b1;
    for (int c = 0; c < hold; c++) begin
      if (c == force_at) begin
        idle();
        mouse(force_dx, '0, '0, 8'h00);
      end else if (pct > 0) begin
        rand_reports(pct);
      end else begin
        idle();
      end
      step();
      if (snapshot_strobe && lat < 0) lat = c + 1;
    end
    idle();
    hid_read = 1'b0;
    repeat (4) step();
    check("strobes_per_read", 64'(strobes - s0), 64'd1);
    check("latency_ok", 64'((lat == SS + 1) || (lat == SS + 2)), 64'd1);
  endtask

  initial begin
    clear_model();
    reset_n = 1'b0; hid_read = 1'b0;
    kbd_connected_in = 1'b0; mouse_connected_in = 1'b0;
    kbd_report_modifiers = '0; kbd_report_keycodes = '0; mouse_report_buttons = '0;
    mouse_report_dx = '0; mouse_report_dy = '0; mouse_report_dwheel = '0;
    idle();
    #2;
    check_outs("reset");
    check("reset_strobe", 64'(snapshot_strobe), 64'd0);
    step(); step();
    reset_n = 1'b1;
    step();

    // Quiet read: one strobe, everything zero.
    do_read(7, 0, -1, '0);
    check("t1_x", 64'(hid_mouse_x), 64'd0);

    // Accumulation over three reports, then an empty read.
    mouse_connected_in = 1'b1;
    step();
    mouse(16'd100, 16'hFFFF, 8'd1, 8'h01); step();
    mouse(-16'sd30, 16'hFFFF, 8'd1, 8'h02); step();
    mouse(16'd5, 16'hFFFF, 8'd1, 8'h03); step();
    idle();
    do_read(7, 0, -1, '0);
    check("t2_x", 64'($signed(hid_mouse_x)), 64'(75));
    check("t2_y", 64'($signed(hid_mouse_y)), 64'(-3));
    check("t2_w", 64'($signed(hid_mouse_wheel)), 64'(3));
    check("t2_btn", 64'(hid_mouse_buttons), 64'h03);
    do_read(7, 0, -1, '0);
    check("t2_x_clear", 64'(hid_mouse_x), 64'd0);

    // Saturation both ways.
    repeat (20) begin mouse(16'h7FFF, 16'h0, 8'h7F, 8'h0); step(); end
    idle();
    do_read(7, 0, -1, '0);
    check("t3_xmax", 64'(hid_mouse_x), 64'({1'b0, {(AW-1){1'b1}}}));
    repeat (20) begin mouse(16'h8000, 16'h0, 8'h80, 8'h0); step(); end
    idle();
    do_read(7, 0, -1, '0);
    check("t3_xmin", 64'(hid_mouse_x), 64'({1'b1, {(AW-1){1'b0}}}));

    // Report at every position through the snapshot window; position 3 is the snapshot cycle.
    for (int k = 0; k < 6; k++) begin
      do_read(8, 0, k, 16'd7);
      if (k == SS + 1) check("t4_snap_incl", 64'(hid_mouse_x), 64'd7);
      do_read(7, 0, -1, '0);
      if (k == SS + 1) check("t4_no_recount", 64'(hid_mouse_x), 64'd0);
    end

    // Keyboard report while a read is in progress appears only on the next read.
    kbd_connected_in = 1'b1;
    hid_read = 1'b1;
    repeat (6) step();
    kbd_report_valid = 1'b1; kbd_report_modifiers = 8'h02;
    kbd_report_keycodes = 48'h0000_0000_0504;
    step();
    idle();
    repeat (2) step();
    check("t5_held_mod", 64'(hid_keyboard_modifiers), 64'h00);
    hid_read = 1'b0;
    repeat (4) step();
    do_read(7, 0, -1, '0);
    check("t5_mod", 64'(hid_keyboard_modifiers), 64'h02);
    check("t5_key0", 64'(hid_keyboard_keycodes[7:0]), 64'h04);
    check("t5_key1", 64'(hid_keyboard_keycodes[15:8]), 64'h05);

    // Mouse disconnect clears and ignores; then reset during a hold.
    mouse(16'd50, 16'd0, 8'd0, 8'h05); step();
    idle();
    mouse_connected_in = 1'b0; step();
    mouse(16'd9, 16'd0, 8'd0, 8'h07); step();
    idle();
    do_read(7, 0, -1, '0);
    check("t6_mc", 64'(hid_mouse_connected), 64'd0);
    check("t6_x", 64'(hid_mouse_x), 64'd0);
    check("t6_btn", 64'(hid_mouse_buttons), 64'd0);
    check("t6_kc", 64'(hid_keyboard_connected), 64'd1);
    hid_read = 1'b1;
    repeat (6) step();
    reset_n = 1'b0;
    #1;
    clear_model();
    check_outs("midreset");
    check("t6_kc_reset", 64'(hid_keyboard_connected), 64'd0);
    step();
    reset_n = 1'b1;
    begin
      int s0;
      s0 = strobes;
      repeat (8) step();
      check("t6_fresh_snap", 64'(strobes - s0), 64'd1);
    end
    hid_read = 1'b0;
    repeat (4) step();

    // Random traffic with occasional connection changes.
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(7) == 0) mouse_connected_in = ~mouse_connected_in;
      if ($urandom_range(7) == 0) kbd_connected_in = ~kbd_connected_in;
      repeat (int'($urandom_range(12))) begin rand_reports(50); step(); end
      do_read(6 + int'($urandom_range(4)), 40, -1, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end
endmodule
